fifo_pkt_reader: RTL and testbench
==================================

Name: fifo_pkt_reader

Overview:
- Read-side consumer for the team's push/pop FIFO. Drives `pop`, samples the combinational read data in the pop cycle, and re-times it onto a valid/ready stream through a 2-entry output buffer.
- Groups beats into fixed-length packets with a `last` flag.
- Gates reading with an enable/drain state machine so a packet is never cut short.
- Sits between any FIFO instance and a downstream stream sink (e.g. DMA or serializer).

Parameters:
- WIDTH, 8, data width; must match the FIFO WIDTH.
- PKT_LEN, 4, beats per packet (>=1).
- PKT_B, $clog2(PKT_LEN)+1, beat-counter width (derived).
- CNT_W, 16, width of the completed-packet counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  level: 1 = read packets, 0 = stop at the next packet boundary.
- flush  input  1  synchronous clear of buffer, beat count and FSM.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd  input  WIDTH  FIFO read data; valid combinationally in the cycle `fifo_pop`=1.
- fifo_pop  output  1  pop strobe to the FIFO (combinational).
- m_valid  output  1  stream beat valid.
- m_ready  input  1  sink ready.
- m_data  output  WIDTH  stream data (registered).
- m_last  output  1  final beat of a packet.
- busy  output  1  FSM not IDLE.
- pkt_count  output  CNT_W  completed packets, wraps.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high, port `rst`.
- Reset values: `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `pkt_count`=0. Buffer count=0, beat counter=0, state=IDLE.
- Priority: rst > flush > normal.
- Output buffer:
  - 2 entries, each {data, last}; occupancy `cnt` ranges 0..2.
  - Head entry drives `m_data`/`m_last`; `m_valid` = (cnt != 0).
- Pop rule:
  - `fifo_pop` = (state is RUN or FINISH) & ~fifo_empty & (cnt < 2) & ~flush & ~rst.
  - `fifo_pop` must not depend on `m_ready` (no combinational ready path).
- Latency: `fifo_rd` is written into the buffer at the edge ending the pop cycle. With an empty buffer, `m_valid` rises one cycle after the pop.
- Throughput: with `m_ready` held 1 and the FIFO non-empty, one beat per cycle in steady state.
- Simultaneous enqueue and dequeue (pop and handshake in the same cycle): `cnt` unchanged; order preserved.
- Packet tagging:
  - An enqueue-side beat counter `eb` (0..PKT_LEN-1) tags each popped beat. last = (eb == PKT_LEN-1).
  - `eb` increments per pop and wraps to 0 after the last beat.
- `pkt_count` increments on a handshake (`m_valid` & `m_ready`) with `m_last`=1; wraps at 2^CNT_W.
- FSM:
  - IDLE: `en`=1 -> RUN.
  - RUN: `en`=0 & `eb`==0 -> IDLE. `en`=0 & `eb`!=0 -> FINISH.
  - FINISH: keep popping until the last beat of the current packet is popped, then -> IDLE; `en` is ignored.
  - Beats already in the buffer continue to drain in IDLE. `busy`=1 in RUN and FINISH.
- Boundary conditions:
  - FIFO empty mid-packet: wait, no pop; the packet stays open indefinitely.
  - `m_ready`=0 with `cnt`=2: no pop; `m_data`/`m_valid`/`m_last` held stable.
  - `m_valid` never drops without a handshake, except on rst or flush.
- Flush:
  - In the flush cycle, `fifo_pop`=0. At the edge: `cnt`=0, `eb`=0, state=IDLE, `m_valid`=0.
  - `pkt_count` is unchanged.
  - Buffered beats are discarded. Already-popped FIFO data is lost; that is the caller's responsibility.
- rst mid-operation: identical to flush, plus `pkt_count`=0 and `m_data`=0.

Decomposition:
- Shared package `fifo_pkg`:
  - State enum `rd_state_t` {IDLE, RUN, FINISH}.
  - Default WIDTH/PKT_LEN constants.
  - Buffer entry struct {data, last}.
- One natural sub-module: `skid_buf2` (2-entry valid/ready buffer with push/`cnt` interface). Beat counter and FSM stay in the top.

Test Plan:
- Basic stream: FIFO preloaded with 0x10..0x17, en=1, m_ready=1 -> 8 pops on consecutive cycles; m_data 0x10..0x17 one per cycle; m_last on 0x13 and 0x17; pkt_count=2.
- Backpressure: m_ready=0 for 5 cycles after the first beat -> fifo_pop stops once cnt=2; m_data held at 0x10; no loss or duplication after release.
- Drain on disable: en dropped after 2 beats popped -> FSM in FINISH; exactly 2 more pops (4 total); then IDLE, busy=0, pkt_count=1.
- FIFO underrun: FIFO holds 2 words, en=1 -> 2 beats, no m_last, busy=1. Push 2 more -> beats 3-4 complete the packet with m_last on beat 4.
- Flush: flush pulsed with cnt=2 mid-packet -> next cycle m_valid=0, busy=0, eb=0; after en=1, the next popped word carries the packet's beat 0 tag.
- Reset: rst asserted while streaming -> at the next edge all outputs are at reset values and no pop occurs during rst.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO packet reader.
package fifo_pkg;

   localparam int unsigned DEF_WIDTH   = 8;
   localparam int unsigned DEF_PKT_LEN = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } rd_state_t;

   typedef struct packed {
      logic [DEF_WIDTH-1:0] data;
      logic                 last;
   } buf_entry_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry valid/ready output buffer with push/occupancy interface.
module skid_buf2
   import fifo_pkg::*;
#(
   parameter type entry_t = buf_entry_t
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       push,
   input  entry_t     push_entry,
   input  logic       ready,
   output logic       valid,
   output entry_t     head,
   output logic [1:0] cnt
);

   entry_t     tail;
   entry_t     head_nxt;
   entry_t     tail_nxt;
   logic [1:0] cnt_nxt;
   logic       deq_c;

   assign deq_c = valid & ready;

   // Head always holds the oldest beat; tail only fills when head is occupied.
   always_comb begin
      head_nxt = head;
      tail_nxt = tail;
      cnt_nxt  = cnt;
      case ({push, deq_c})
         2'b10: begin
            if (cnt == 2'd0) head_nxt = push_entry;
            else             tail_nxt = push_entry;
            cnt_nxt = cnt + 2'd1;
         end
         2'b01: begin
            head_nxt = tail;
            cnt_nxt  = cnt - 2'd1;
         end
         2'b11: begin
            if (cnt == 2'd1) begin
               head_nxt = push_entry;
            end else begin
               head_nxt = tail;
               tail_nxt = push_entry;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         cnt   <= 2'd0;
         valid <= 1'b0;
      end else if (clr) begin
         cnt   <= 2'd0;
         valid <= 1'b0;
      end else begin
         head  <= head_nxt;
         tail  <= tail_nxt;
         cnt   <= cnt_nxt;
         valid <= (cnt_nxt != 2'd0);
      end
   end

endmodule

// File: rtl/fifo_pkt_reader.sv
// Pops a FIFO into a valid/ready stream, grouping beats into fixed-length packets.
module fifo_pkt_reader
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned PKT_LEN = DEF_PKT_LEN,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_rd,
   output logic             fifo_pop,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last,
   output logic             busy,
   output logic [CNT_W-1:0] pkt_count
);

   localparam int unsigned PKT_B = $clog2(PKT_LEN) + 1;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             last;
   } entry_t;

   rd_state_t        state;
   rd_state_t        state_nxt;
   logic [PKT_B-1:0] eb;
   logic [PKT_B-1:0] eb_nxt;
   logic             last_beat;
   logic [1:0]       cnt;
   entry_t           push_entry;
   entry_t           head;

   assign last_beat  = (eb == PKT_B'(PKT_LEN - 1));
   assign push_entry = '{data: fifo_rd, last: last_beat};
   assign m_data     = head.data;
   assign m_last     = head.last;

   // Leaving RUN looks at the post-pop beat index so a pop in the same cycle
   // as en falling still gets its packet completed.
   always_comb begin
      state_nxt = state;
      eb_nxt    = eb;
      fifo_pop  = 1'b0;
      if ((state == RUN || state == FINISH) && !fifo_empty && (cnt < 2'd2) && !flush && !rst)
         fifo_pop = 1'b1;
      if (fifo_pop)
         eb_nxt = last_beat ? '0 : eb + PKT_B'(1);
      case (state)
         IDLE:    if (en) state_nxt = RUN;
         RUN:     if (!en) state_nxt = (eb_nxt == '0) ? IDLE : FINISH;
         FINISH:  if (fifo_pop && last_beat) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         eb        <= '0;
         busy      <= 1'b0;
         pkt_count <= '0;
      end else if (flush) begin
         state <= IDLE;
         eb    <= '0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         eb    <= eb_nxt;
         busy  <= (state_nxt != IDLE);
         if (m_valid && m_ready && m_last)
            pkt_count <= pkt_count + CNT_W'(1);
      end
   end

   skid_buf2 #(
      .entry_t (entry_t)
   ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .clr        (flush),
      .push       (fifo_pop),
      .push_entry (push_entry),
      .ready      (m_ready),
      .valid      (m_valid),
      .head       (head),
      .cnt        (cnt)
   );

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Scoreboard bench for fifo_pkt_reader with a behavioural FIFO model.
module tb_fifo_pkt_reader;

   localparam int PKT_LEN = 4;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, en, flush, fifo_empty, m_ready;
   logic [7:0]  fifo_rd;
   logic        fifo_pop, m_valid, m_last, busy;
   logic [7:0]  m_data;
   logic [15:0] pkt_count;

   logic [7:0] fifo_q[$];
   exp_t       exp_q[$];
   int checks = 0, errors = 0;
   int cyc = 0, ebm = 0, pkt_m = 0;
   int n_pop, n_hs, n_last, first_pop_cyc, last_pop_cyc, first_valid_cyc;

   always #5 clk = ~clk;

   fifo_pkt_reader dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .flush      (flush),
      .fifo_empty (fifo_empty),
      .fifo_rd    (fifo_rd),
      .fifo_pop   (fifo_pop),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .busy       (busy),
      .pkt_count  (pkt_count)
   );

   task automatic refresh();
      fifo_empty = (fifo_q.size() == 0);
      fifo_rd    = fifo_empty ? 8'h00 : fifo_q[0];
   endtask

   task automatic load(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back(8'(first + 8'(i)));
      refresh();
   endtask

   task automatic clr_stats();
      n_pop = 0; n_hs = 0; n_last = 0;
      first_pop_cyc = -1; last_pop_cyc = -1; first_valid_cyc = -1;
   endtask

   // One clock: sample mid-cycle, score handshakes and pops, advance the FIFO model.
   task automatic tick();
      logic pop_now, hs_now;
      exp_t e;
      #1;
      pop_now = fifo_pop;
      hs_now  = m_valid && m_ready;
      if (m_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (hs_now) begin
         checks++;
         n_hs++;
         if (m_last) n_last++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL hs_unexpected data=%h last=%b", m_data, m_last);
         end else begin
            e = exp_q.pop_front();
            if (m_data !== e.data || m_last !== e.last) begin
               errors++;
               $display("FAIL hs_beat got data=%h last=%b exp data=%h last=%b",
                        m_data, m_last, e.data, e.last);
            end
            if (e.last) pkt_m++;
         end
      end
      if (pop_now && fifo_q.size() != 0) begin
         exp_q.push_back('{data: fifo_q[0], last: (ebm == PKT_LEN - 1)});
         ebm = (ebm == PKT_LEN - 1) ? 0 : ebm + 1;
         n_pop++;
         if (first_pop_cyc < 0) first_pop_cyc = cyc;
         last_pop_cyc = cyc;
      end
      if (flush || rst) begin
         exp_q.delete();
         ebm = 0;
         if (rst) pkt_m = 0;
      end
      @(posedge clk);
      #1;
      if (pop_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
      refresh();
      cyc++;
   endtask

   task automatic cleanup();
      en = 1'b0; m_ready = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      fifo_q.delete();
      refresh();
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
      refresh();
      tick(); tick();
      checks++;
      if (m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0 || busy !== 1'b0 ||
          pkt_count !== 16'h0 || fifo_pop !== 1'b0) begin
         errors++;
         $display("FAIL reset_vals got v=%b d=%h l=%b busy=%b cnt=%0d pop=%b exp all 0",
                  m_valid, m_data, m_last, busy, pkt_count, fifo_pop);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      clr_stats();
      load(8'h10, 8);
      en = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < 40 && n_hs < 8; i++) tick();
      checks++;
      if (n_hs != 8 || n_pop != 8) begin
         errors++; $display("FAIL basic_count got hs=%0d pop=%0d exp 8/8", n_hs, n_pop);
      end
      checks++;
      if (last_pop_cyc - first_pop_cyc != 7) begin
         errors++; $display("FAIL basic_rate got span=%0d exp 7", last_pop_cyc - first_pop_cyc);
      end
      checks++;
      if (first_valid_cyc != first_pop_cyc + 1) begin
         errors++; $display("FAIL basic_latency got valid@%0d pop@%0d exp pop+1", first_valid_cyc, first_pop_cyc);
      end
      checks++;
      if (n_last != 2 || pkt_count !== 16'd2) begin
         errors++; $display("FAIL basic_pkts got last=%0d pkt=%0d exp 2/2", n_last, pkt_count);
      end
      en = 1'b0;
      tick(); tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL basic_idle got busy=%b exp 0", busy);
      end
   endtask

   task automatic test_backpressure();
      clr_stats();
      load(8'h10, 8);
      en = 1'b1; m_ready = 1'b0;
      for (int i = 0; i < 10 && m_valid !== 1'b1; i++) tick();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (m_valid !== 1'b1 || m_data !== 8'h10) begin
            errors++; $display("FAIL bp_hold got v=%b d=%h exp 1/10", m_valid, m_data);
         end
         tick();
      end
      checks++;
      if (n_pop != 2) begin
         errors++; $display("FAIL bp_stall got pops=%0d exp 2", n_pop);
      end
      m_ready = 1'b1;
      for (int i = 0; i < 40 && n_hs < 8; i++) tick();
      checks++;
      if (n_hs != 8 || exp_q.size() != 0 || fifo_q.size() != 0) begin
         errors++; $display("FAIL bp_release got hs=%0d pend=%0d fifo=%0d exp 8/0/0",
                            n_hs, exp_q.size(), fifo_q.size());
      end
      en = 1'b0;
      tick(); tick();
   endtask

   task automatic test_drain();
      int base;
      base = pkt_m;
      clr_stats();
      load(8'h30, 8);
      en = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < 20 && n_pop < 2; i++) tick();
      en = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL drain_finish got busy=%b exp 1", busy);
      end
      for (int i = 0; i < 20 && (busy !== 1'b0 || exp_q.size() != 0); i++) tick();
      tick(); tick();
      checks++;
      if (n_pop != 4 || busy !== 1'b0) begin
         errors++; $display("FAIL drain_pops got pops=%0d busy=%b exp 4/0", n_pop, busy);
      end
      checks++;
      if (pkt_count !== 16'(base + 1) || fifo_q.size() != 4) begin
         errors++; $display("FAIL drain_pkt got pkt=%0d fifo=%0d exp %0d/4", pkt_count, fifo_q.size(), base + 1);
      end
      cleanup();
   endtask

   task automatic test_underrun();
      int base;
      base = pkt_m;
      clr_stats();
      load(8'h40, 2);
      en = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      checks++;
      if (n_hs != 2 || n_last != 0 || busy !== 1'b1) begin
         errors++; $display("FAIL under_wait got hs=%0d last=%0d busy=%b exp 2/0/1", n_hs, n_last, busy);
      end
      load(8'h42, 2);
      for (int i = 0; i < 10; i++) tick();
      checks++;
      if (n_hs != 4 || n_last != 1 || pkt_count !== 16'(base + 1)) begin
         errors++; $display("FAIL under_done got hs=%0d last=%0d pkt=%0d exp 4/1/%0d",
                            n_hs, n_last, pkt_count, base + 1);
      end
      en = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL under_idle got busy=%b exp 0", busy);
      end
   endtask

   task automatic test_flush();
      int base;
      base = pkt_m;
      clr_stats();
      load(8'h50, 8);
      en = 1'b1; m_ready = 1'b0;
      for (int i = 0; i < 20 && n_pop < 2; i++) tick();
      tick(); tick(); tick();
      checks++;
      if (n_pop != 2 || m_valid !== 1'b1 || m_data !== 8'h50) begin
         errors++; $display("FAIL flush_pre got pops=%0d v=%b d=%h exp 2/1/50", n_pop, m_valid, m_data);
      end
      flush = 1'b1;
      #1;
      checks++;
      if (fifo_pop !== 1'b0) begin
         errors++; $display("FAIL flush_nopop got pop=%b exp 0", fifo_pop);
      end
      tick();
      flush = 1'b0;
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0 || pkt_count !== 16'(base)) begin
         errors++; $display("FAIL flush_state got v=%b busy=%b pkt=%0d exp 0/0/%0d",
                            m_valid, busy, pkt_count, base);
      end
      n_hs = 0; n_last = 0;
      m_ready = 1'b1;
      for (int i = 0; i < 30 && n_hs < 4; i++) tick();
      checks++;
      if (n_hs != 4 || n_last != 1 || pkt_count !== 16'(base + 1)) begin
         errors++; $display("FAIL flush_retag got hs=%0d last=%0d pkt=%0d exp 4/1/%0d",
                            n_hs, n_last, pkt_count, base + 1);
      end
      cleanup();
   endtask

   task automatic test_reset_mid();
      clr_stats();
      load(8'h60, 8);
      en = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1; m_ready = 1'b0;
      #1;
      checks++;
      if (fifo_pop !== 1'b0) begin
         errors++; $display("FAIL rst_nopop got pop=%b exp 0", fifo_pop);
      end
      tick();
      checks++;
      if (m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0 || busy !== 1'b0 ||
          pkt_count !== 16'h0) begin
         errors++;
         $display("FAIL rst_mid got v=%b d=%h l=%b busy=%b pkt=%0d exp all 0",
                  m_valid, m_data, m_last, busy, pkt_count);
      end
      rst = 1'b0;
      cleanup();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_drain();
      test_underrun();
      test_flush();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
